// File: rtl/disp_pkg.sv
// Shared types and seven-segment constants for the result display path.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package disp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Non-decimal nibbles cannot come out of the converter; show them blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin_a_bcd.sv
// Sequential double-dabble converter: one bit per clock, WIDTH clocks per value.
// done is high during the cycle whose closing edge performs the final shift.
module bin_a_bcd #(
    parameter int WIDTH  = 12,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]    r_bin;
    logic [4*DIGITS-1:0] r_bcd;
    logic [CW-1:0]       r_cnt;
    logic                r_run;
    logic [4*DIGITS-1:0] w_adj;
    logic                w_last;

    // Add-3 correction on every nibble that would overflow past 9 after the shift.
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end else begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4];
            end
        end
    end

    assign w_last = r_run && (r_cnt == CW'(WIDTH - 1));

    // Shift register, BCD accumulator and bit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin <= '0;
            r_bcd <= '0;
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (start) begin
            r_bin <= bin;
            r_bcd <= '0;
            r_cnt <= '0;
            r_run <= 1'b1;
        end else if (r_run) begin
            r_bcd <= {w_adj[4*DIGITS-2:0], r_bin[WIDTH-1]};
            r_bin <= {r_bin[WIDTH-2:0], 1'b0};
            r_cnt <= r_cnt + CW'(1);
            r_run <= !w_last;
        end else begin
            r_bin <= r_bin;
            r_bcd <= r_bcd;
            r_cnt <= r_cnt;
            r_run <= r_run;
        end
    end

    assign done = w_last;
    assign bcd  = r_bcd;

endmodule

// File: rtl/muestra_resultado.sv
// Result display: accepts a binary value, converts it to BCD and drives a
// multiplexed active-low seven-segment display with leading-zero blanking.
module muestra_resultado
    import disp_pkg::*;
#(
    parameter int WIDTH       = 12,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 27000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  valor,
    input  logic              valor_valid,
    output logic              listo,
    output logic              ocupado,
    output logic [DIGITS-1:0] anodo,
    output logic [6:0]        segmentos
);

    localparam longint MAX_BIN = (longint'(1) << WIDTH) - longint'(1);
    localparam longint MAX_BCD = (longint'(10) ** DIGITS) - longint'(1);
    localparam int     CNT_W   = $clog2(REFRESH_DIV);
    localparam int     IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    if (MAX_BIN > MAX_BCD) begin : g_width_check
        $error("muestra_resultado: WIDTH too large for DIGITS decimal digits");
    end
    if (REFRESH_DIV < 2) begin : g_div_check
        $error("muestra_resultado: REFRESH_DIV must be at least 2");
    end

    state_t              r_state;
    state_t              w_state_next;
    logic                w_start;
    logic                w_latch;
    logic                w_done;
    logic [4*DIGITS-1:0] w_bcd;
    logic [4*DIGITS-1:0] r_disp;
    logic [4*DIGITS-1:0] w_disp_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_next;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    w_idx_next;
    logic [DIGITS-1:0]   w_blank;
    logic                w_higher_nz;
    logic [3:0]          w_digit;
    logic [6:0]          w_seg_next;
    logic                r_listo;
    logic                r_ocupado;
    logic [DIGITS-1:0]   r_anodo;
    logic [6:0]          r_seg;

    bin_a_bcd #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_bin_a_bcd (
        .clk   (clk),
        .rst   (rst),
        .start (w_start),
        .bin   (valor),
        .done  (w_done),
        .bcd   (w_bcd)
    );

    // Handshake/conversion state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, converter start and display latch strobe.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_latch      = 1'b0;
        case (r_state)
            IDLE: begin
                if (valor_valid) begin
                    w_start      = 1'b1;
                    w_state_next = SHIFT;
                end else begin
                    w_state_next = IDLE;
                end
            end
            SHIFT: begin
                if (w_done) begin
                    w_state_next = LATCH;
                end else begin
                    w_state_next = SHIFT;
                end
            end
            LATCH: begin
                w_latch      = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Outputs are computed from next-cycle values so the registers line up with the display state.
    always_comb begin
        w_disp_next = w_latch ? w_bcd : r_disp;
        w_cnt_next  = (r_cnt == CNT_W'(REFRESH_DIV - 1)) ? '0 : r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(REFRESH_DIV - 1)) begin
            w_idx_next = (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
        end else begin
            w_idx_next = r_idx;
        end
    end

    // Leading-zero blanking, scanned from the most significant digit down.
    always_comb begin
        w_higher_nz = 1'b0;
        w_blank     = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_higher_nz = w_higher_nz | (w_disp_next[4*i +: 4] != 4'd0);
            w_blank[i]  = (i != 0) && !w_higher_nz;
        end
    end

    // Segment pattern for the digit slot selected next cycle.
    always_comb begin
        w_digit    = w_disp_next[{w_idx_next, 2'b00} +: 4];
        w_seg_next = w_blank[w_idx_next] ? SEG_BLANK : seg_decode(w_digit);
    end

    // Display register, scan counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_disp    <= '0;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_listo   <= 1'b1;
            r_ocupado <= 1'b0;
            r_anodo   <= ~DIGITS'(1);
            r_seg     <= SEG_0;
        end else begin
            r_disp    <= w_disp_next;
            r_cnt     <= w_cnt_next;
            r_idx     <= w_idx_next;
            r_listo   <= (w_state_next == IDLE);
            r_ocupado <= (w_state_next != IDLE);
            r_anodo   <= ~(DIGITS'(1) << w_idx_next);
            r_seg     <= w_seg_next;
        end
    end

    assign listo     = r_listo;
    assign ocupado   = r_ocupado;
    assign anodo     = r_anodo;
    assign segmentos = r_seg;

endmodule

// File: tb/tb_muestra_resultado.sv
// Directed bench for muestra_resultado with a short refresh divider.
module tb_muestra_resultado;

    localparam int WIDTH  = 12;
    localparam int DIGITS = 4;
    localparam int RDIV   = 4;

    localparam logic [6:0] P0 = 7'b1000000;
    localparam logic [6:0] P1 = 7'b1111001;
    localparam logic [6:0] P3 = 7'b0110000;
    localparam logic [6:0] P4 = 7'b0011001;
    localparam logic [6:0] P5 = 7'b0010010;
    localparam logic [6:0] P7 = 7'b1111000;
    localparam logic [6:0] P8 = 7'b0000000;
    localparam logic [6:0] P9 = 7'b0010000;
    localparam logic [6:0] BL = 7'b1111111;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] valor;
    logic             valor_valid;
    logic             listo;
    logic             ocupado;
    logic [3:0]       anodo;
    logic [6:0]       segmentos;

    int         checks   = 0;
    int         failures = 0;
    int         tb_cyc   = 0;
    logic [6:0] exp_seg [4];

    muestra_resultado #(
        .WIDTH       (WIDTH),
        .DIGITS      (DIGITS),
        .REFRESH_DIV (RDIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .valor       (valor),
        .valor_valid (valor_valid),
        .listo       (listo),
        .ocupado     (ocupado),
        .anodo       (anodo),
        .segmentos   (segmentos)
    );

    always #5 clk = ~clk;

    // Reference scan position: edges counted since reset was last released.
    always @(posedge clk) begin
        if (rst) tb_cyc <= 0;
        else     tb_cyc <= tb_cyc + 1;
    end

    function automatic int cur_idx();
        return (tb_cyc / RDIV) % DIGITS;
    endfunction

    function automatic logic [3:0] exp_anodo();
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << cur_idx());
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full scan rotation: anodo follows the reference, segments match exp_seg.
    task automatic scan(input string tag);
        for (int k = 0; k < RDIV * DIGITS; k++) begin
            @(negedge clk);
            chk($sformatf("%s_anodo", tag), anodo, exp_anodo());
            chk($sformatf("%s_seg_d%0d", tag, cur_idx()), segmentos, exp_seg[cur_idx()]);
        end
    endtask

    task automatic send(input logic [WIDTH-1:0] v);
        @(negedge clk);
        chk("listo_before_send", listo, 1'b1);
        valor       = v;
        valor_valid = 1'b1;
        @(negedge clk);
        valor_valid = 1'b0;
        chk("accepted", listo, 1'b0);
    endtask

    // Counts remaining busy cycles while checking the old value is still displayed.
    task automatic wait_ready(input string tag, input int exp_low);
        int n;
        n = 0;
        while (listo === 1'b0 && n < 100) begin
            chk($sformatf("%s_ocupado", tag), ocupado, 1'b1);
            chk($sformatf("%s_hold_d%0d", tag, cur_idx()), segmentos, exp_seg[cur_idx()]);
            n++;
            @(negedge clk);
        end
        chk($sformatf("%s_busy_cycles", tag), n, exp_low);
        chk($sformatf("%s_ocupado_low", tag), ocupado, 1'b0);
    endtask

    initial begin
        rst         = 1'b1;
        valor       = '0;
        valor_valid = 1'b0;
        exp_seg     = '{P0, BL, BL, BL};
        repeat (3) @(negedge clk);
        chk("rst_listo", listo, 1'b1);
        chk("rst_ocupado", ocupado, 1'b0);
        chk("rst_anodo", anodo, 4'b1110);
        chk("rst_seg", segmentos, P0);
        rst = 1'b0;
        scan("reset_scan");

        send(12'd1998);
        wait_ready("v1998", 13);
        exp_seg = '{P8, P9, P9, P1};
        scan("v1998");

        send(12'd7);
        wait_ready("v7", 13);
        exp_seg = '{P7, BL, BL, BL};
        scan("v7");

        send(12'd0);
        wait_ready("v0", 13);
        exp_seg = '{P0, BL, BL, BL};
        scan("v0");

        // 4095 offered three cycles after 305 was accepted must be dropped.
        send(12'd305);
        repeat (2) @(negedge clk);
        valor       = 12'd4095;
        valor_valid = 1'b1;
        @(negedge clk);
        valor_valid = 1'b0;
        wait_ready("v305", 10);
        exp_seg = '{P5, P0, P3, BL};
        repeat (5) begin
            @(negedge clk);
            chk("v305_no_requeue", listo, 1'b1);
        end
        scan("v305");

        send(12'd4095);
        wait_ready("v4095", 13);
        exp_seg = '{P5, P9, P0, P4};
        scan("v4095");

        // Reset in the middle of converting 1234.
        send(12'd1234);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_listo", listo, 1'b1);
        chk("midrst_ocupado", ocupado, 1'b0);
        chk("midrst_anodo", anodo, 4'b1110);
        chk("midrst_seg", segmentos, P0);
        @(negedge clk);
        rst     = 1'b0;
        exp_seg = '{P0, BL, BL, BL};
        repeat (20) begin
            @(negedge clk);
            chk("midrst_idle", listo, 1'b1);
        end
        scan("midrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
